// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: feeds one nibble per cycle to an external
// combinational 4-bit adder and collects the sum, rippling carry in a register.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_q[{idx_q, 2'b00} +: 4];
                add_b   = b_q[{idx_q, 2'b00} +: 4];
                add_cin = carry_q;
                // Sum bits come only from the external adder.
                result_d[{idx_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = result_q;
                out_cout  = carry_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed + random bench for nibble_serial_add_ctrl (NIBBLES=4) with a
// behavioural 4-bit adder on the add_* ports and an arithmetic reference model.
module tb_nibble_serial_add_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
    logic [3:0]     add_a;
    logic [3:0]     add_b;
    logic           add_cin;
    logic [3:0]     add_sum;
    logic           add_cout;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External fourbitadder stand-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Carry entering nibble i: carry out of the low i nibbles added as integers.
    function automatic logic ref_carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input int i);
        longint unsigned m, s;
        m = 64'd1 << (4 * i);
        s = (longint'(a) % m) + (longint'(b) % m) + longint'(c);
        return (s >= m);
    endfunction

    // Offer one op in IDLE, check latency, add_* sequence and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit release_out);
        logic [W:0] exp;
        int k;
        exp = ref_add(a, b, c);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            chk({tag, "_add_cin"}, 32'(add_cin), 32'(ref_carry_in(a, b, c, k)));
            chk({tag, "_add_a"}, 32'(add_a), 32'((a >> (4 * k)) & 16'hF));
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(NIB));
        chk({tag, "_sum"}, 32'(out_sum), 32'(exp[W-1:0]));
        chk({tag, "_cout"}, 32'(out_cout), 32'(exp[W]));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_back_idle"}, 32'({in_ready, out_valid, busy}), 32'b100);
        end
    endtask

    initial begin
        logic [W-1:0] sum_hold;
        logic         cout_hold;
        logic [W-1:0] ra [3];
        logic [W-1:0] rb [3];
        logic         rc [3];
        logic [W:0]   exp;
        int           acc_cyc [3];
        int           k;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_outs", 32'({out_valid, out_cout, busy, add_cin}), 32'd0);
        chk("reset_sum", 32'(out_sum), 32'd0);
        chk("reset_add", 32'({add_a, add_b}), 32'd0);

        run_op("t1", 16'h0001, 16'h0001, 1'b0, 1'b1);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b1, 1'b1);
        run_op("t3", 16'h0F0F, 16'h00F1, 1'b0, 1'b1);

        // Backpressure in DONE
        run_op("t4", 16'hABCD, 16'h1357, 1'b1, 1'b0);
        sum_hold = out_sum; cout_hold = out_cout;
        in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_sum", 32'(out_sum), 32'(sum_hold));
            chk("t4_hold_flags", 32'({out_valid, out_cout, in_ready}), 32'({1'b1, cout_hold, 1'b0}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_release", 32'({in_ready, out_valid, busy}), 32'b100);
        @(negedge clk);
        chk("t4_no_accept", 32'({in_ready, busy}), 32'b10);

        // Reset mid-operation at idx==2
        @(negedge clk);
        in_a = 16'h9876; in_b = 16'h5432; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_idx2", 32'(add_a), 32'h8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_after_rst", 32'({in_ready, out_valid, busy}), 32'b100);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        chk("t5_no_stale_valid", 32'(k), 32'd0);
        run_op("t5_op", 16'h1234, 16'h4321, 1'b0, 1'b1);

        // Random ops, handshake-driven release
        for (int i = 0; i < 4; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        // in_valid/out_ready held high, back-to-back
        for (int i = 0; i < 3; i++) begin
            ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = 1'($urandom);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_a = ra[0]; in_b = rb[0]; in_cin = rc[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("t6_accept_seen", 32'(in_ready), 32'd1);
            acc_cyc[i] = cyc;
            @(negedge clk);
            if (i < 2) begin
                in_a = ra[i+1]; in_b = rb[i+1]; in_cin = rc[i+1];
            end
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            exp = ref_add(ra[i], rb[i], rc[i]);
            chk("t6_sum", 32'(out_sum), 32'(exp[W-1:0]));
            chk("t6_cout", 32'(out_cout), 32'(exp[W]));
            if (i > 0) chk("t6_period", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(NIB + 2));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        chk("end_idle", 32'({in_ready, busy, out_valid}), 32'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
